// File: rtl/elbeth_trap_unit_pkg.sv
// Shared definitions for the elbeth trap sequencer: FSM states, exception
// cause codes, privilege encodings and the ecall cause helper.
package elbeth_trap_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic [3:0] ECODE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] ECODE_INSTR_FAULT      = 4'd1;
  localparam logic [3:0] ECODE_ILLEGAL          = 4'd2;
  localparam logic [3:0] ECODE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] ECODE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] ECODE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] ECODE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] ECODE_STORE_FAULT      = 4'd7;
  localparam logic [3:0] ECODE_ECALL_U          = 4'd8;
  localparam logic [3:0] ECODE_NONE             = 4'd0;

  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_S = 2'd1;
  localparam logic [1:0] PRV_M = 2'd3;

  // Environment calls encode the caller's privilege in the cause.
  function automatic logic [3:0] ecall_code(input logic [1:0] prv);
    return ECODE_ECALL_U + {2'b00, prv};
  endfunction

endpackage

// File: rtl/elbeth_trap_unit_if.sv
// Pipeline/CSR-facing signal bundle of the trap sequencer. The slave modport
// is the trap unit's view; master is the pipeline/CSR side driving it.
interface elbeth_trap_unit_if #(parameter int XLEN = 32);
  logic            if_misaligned, if_fault;
  logic [XLEN-1:0] if_pc;
  logic            id_illegal, id_ecall, id_ebreak, id_eret;
  logic [XLEN-1:0] id_pc;
  logic            mem_misaligned, mem_fault, mem_is_store, mem_busy;
  logic [XLEN-1:0] mem_addr, mem_pc;
  logic            wb_retire;
  logic [1:0]      prv;
  logic            io_interrupt;
  logic [XLEN-1:0] handler_pc, epc;

  logic            exception, eret;
  logic [3:0]      exception_code;
  logic [XLEN-1:0] exception_pc, exception_load_addr;
  logic            retire, stall, flush, redirect_valid, wait_timeout;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output if_misaligned, if_fault, if_pc, id_illegal, id_ecall, id_ebreak, id_eret, id_pc,
           mem_misaligned, mem_fault, mem_is_store, mem_busy, mem_addr, mem_pc,
           wb_retire, prv, io_interrupt, handler_pc, epc,
    input  exception, eret, exception_code, exception_pc, exception_load_addr,
           retire, stall, flush, redirect_valid, redirect_pc, wait_timeout
  );

  modport slave (
    input  if_misaligned, if_fault, if_pc, id_illegal, id_ecall, id_ebreak, id_eret, id_pc,
           mem_misaligned, mem_fault, mem_is_store, mem_busy, mem_addr, mem_pc,
           wb_retire, prv, io_interrupt, handler_pc, epc,
    output exception, eret, exception_code, exception_pc, exception_load_addr,
           retire, stall, flush, redirect_valid, redirect_pc, wait_timeout
  );
endinterface

// File: rtl/elbeth_trap_priority.sv
// Combinational trap source selector: oldest stage wins (MEM > ID > IF).
// Interrupt source present only when ELBETH_TRAP_INTERRUPT_EN is defined.
module elbeth_trap_priority
  import elbeth_trap_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            if_misaligned,
  input  logic            if_fault,
  input  logic [XLEN-1:0] if_pc,
  input  logic            id_illegal,
  input  logic            id_ecall,
  input  logic            id_ebreak,
  input  logic            id_eret,
  input  logic [XLEN-1:0] id_pc,
  input  logic            mem_misaligned,
  input  logic            mem_fault,
  input  logic            mem_is_store,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_pc,
  input  logic [1:0]      prv,
`ifdef ELBETH_TRAP_INTERRUPT_EN
  input  logic            io_interrupt,
`endif
  output logic            valid,
  output logic [3:0]      code,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] addr,
  output logic            is_eret
);

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    valid   = 1'b1;
    code    = ECODE_NONE;
    pc      = '0;
    addr    = '0;
    is_eret = 1'b0;
    if (mem_misaligned) begin
      code = mem_is_store ? ECODE_STORE_MISALIGNED : ECODE_LOAD_MISALIGNED;
      pc   = mem_pc;
      addr = mem_addr;
    end else if (mem_fault) begin
      code = mem_is_store ? ECODE_STORE_FAULT : ECODE_LOAD_FAULT;
      pc   = mem_pc;
      addr = mem_addr;
    end else if (id_illegal) begin
      code = ECODE_ILLEGAL;
      pc   = id_pc;
    end else if (id_ebreak) begin
      code = ECODE_BREAKPOINT;
      pc   = id_pc;
    end else if (id_ecall) begin
      code = ecall_code(prv);
      pc   = id_pc;
    end else if (id_eret) begin
      is_eret = 1'b1;
      pc      = id_pc;
    end else if (if_misaligned) begin
      code = ECODE_INSTR_MISALIGNED;
      pc   = if_pc;
    end else if (if_fault) begin
      code = ECODE_INSTR_FAULT;
      pc   = if_pc;
`ifdef ELBETH_TRAP_INTERRUPT_EN
    end else if (io_interrupt) begin
      // Cause is supplied by the CSR file; only the resume PC matters here.
      pc = id_pc;
`endif
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/elbeth_trap_unit.sv
// Trap sequencer ahead of the CSR file: capture, drain memory, commit, redirect.
// Optional interrupt source enabled by defining ELBETH_TRAP_INTERRUPT_EN.
module elbeth_trap_unit
  import elbeth_trap_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int WAIT_LIMIT = 15
) (
  input logic                clk,
  input logic                rst,
  elbeth_trap_unit_if.slave  bus
);

  localparam int CNT_W = ($clog2(WAIT_LIMIT + 1) > 4) ? $clog2(WAIT_LIMIT + 1) : 4;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              forced;
  logic              sel_valid, sel_eret, capture, timeout_hit;
  logic [3:0]        sel_code, hold_code;
  logic [XLEN-1:0]   sel_pc, sel_addr, hold_pc, hold_addr;
  logic              hold_eret;

  elbeth_trap_priority #(.XLEN(XLEN)) u_priority (
    .if_misaligned  (bus.if_misaligned),
    .if_fault       (bus.if_fault),
    .if_pc          (bus.if_pc),
    .id_illegal     (bus.id_illegal),
    .id_ecall       (bus.id_ecall),
    .id_ebreak      (bus.id_ebreak),
    .id_eret        (bus.id_eret),
    .id_pc          (bus.id_pc),
    .mem_misaligned (bus.mem_misaligned),
    .mem_fault      (bus.mem_fault),
    .mem_is_store   (bus.mem_is_store),
    .mem_addr       (bus.mem_addr),
    .mem_pc         (bus.mem_pc),
    .prv            (bus.prv),
`ifdef ELBETH_TRAP_INTERRUPT_EN
    .io_interrupt   (bus.io_interrupt),
`endif
    .valid          (sel_valid),
    .code           (sel_code),
    .pc             (sel_pc),
    .addr           (sel_addr),
    .is_eret        (sel_eret)
  );

`ifndef ELBETH_TRAP_INTERRUPT_EN
  logic unused_irq;
  assign unused_irq = bus.io_interrupt;
`endif

  assign capture     = (state == ST_IDLE) && sel_valid;
  assign timeout_hit = (state == ST_WAIT_MEM) && bus.mem_busy &&
                       (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (capture) state_nxt = bus.mem_busy ? ST_WAIT_MEM : ST_COMMIT;
      ST_WAIT_MEM: if (!bus.mem_busy || timeout_hit) state_nxt = ST_COMMIT;
      ST_COMMIT:   state_nxt = ST_REDIRECT;
      ST_REDIRECT: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      forced   <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT_MEM) ? wait_cnt + 1'b1 : '0;
      if (capture)          forced <= 1'b0;
      else if (timeout_hit) forced <= 1'b1;
    end
  end

  // NOTE: holding registers carry no reset; they are only visible while the
  // FSM sits in COMMIT/REDIRECT, which is always preceded by a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      hold_code <= sel_code;
      hold_pc   <= sel_pc;
      hold_addr <= sel_addr;
      hold_eret <= sel_eret;
    end
  end

  // Reset masks every output so a trap caught mid-flight emits no strobe.
  always_comb begin
    bus.exception           = 1'b0;
    bus.eret                = 1'b0;
    bus.exception_code      = '0;
    bus.exception_pc        = '0;
    bus.exception_load_addr = '0;
    bus.retire              = 1'b0;
    bus.stall               = 1'b0;
    bus.flush               = 1'b0;
    bus.redirect_valid      = 1'b0;
    bus.redirect_pc         = '0;
    bus.wait_timeout        = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          bus.stall  = capture;
          bus.retire = bus.wb_retire && !capture;
        end
        ST_WAIT_MEM: bus.stall = 1'b1;
        ST_COMMIT: begin
          bus.stall               = 1'b1;
          bus.flush               = 1'b1;
          bus.exception           = !hold_eret;
          bus.eret                = hold_eret;
          bus.exception_code      = hold_code;
          bus.exception_pc        = hold_pc;
          bus.exception_load_addr = hold_addr;
          bus.wait_timeout        = forced;
        end
        ST_REDIRECT: begin
          bus.stall          = 1'b1;
          bus.flush          = 1'b1;
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = hold_eret ? bus.epc : bus.handler_pc;
        end
        default: ;
      endcase
    end
  end

endmodule
